watch_time_setter: RTL and testbench
====================================

Name: watch_time_setter

Overview:
- Consumer side of the button one-shot path.
- Takes the single-cycle pulses produced from the watch buttons and keeps wall-clock time (hours, minutes, seconds) on userclock.
- Implements the user time-setting state machine: mode button cycles RUN -> SET_HOUR -> SET_MIN -> RUN; increment button advances the selected field.
- Outputs feed the display/BCD block.

Parameters:
- CLK_HZ, 50000000, userclock frequency; prescaler terminal count is CLK_HZ-1 (sim uses 10).
- BLINK_DIV, 2, blink toggles every BLINK_DIV second-ticks while in a SET state.

Ports:
- userclock  input  1  system clock, all logic on rising edge
- reset_n  input  1  asynchronous active-low reset
- mode_pulse  input  1  one-cycle pulse, mode button pressed (already synchronous to userclock)
- inc_pulse  input  1  one-cycle pulse, increment button pressed (already synchronous)
- hours  output  5  0..23
- minutes  output  6  0..59
- seconds  output  6  0..59
- set_mode  output  2  0=RUN, 1=SET_HOUR, 2=SET_MIN (3 never driven)
- blink  output  1  display blank strobe for the field being set; 0 in RUN
- sec_tick  output  1  one-cycle pulse when seconds advance in RUN

Behaviour:
- Reset (reset_n low, async): hours=0, minutes=0, seconds=0, set_mode=RUN, blink=0, sec_tick=0, prescaler=0, blink counter=0. Release is synchronous in effect; first count happens on the edge after deassertion.
- Prescaler:
  - counts 0..CLK_HZ-1 every cycle; tick asserted the cycle count==CLK_HZ-1, count wraps to 0.
  - Runs in all states.
- RUN state, on tick:
  - seconds+1; at 59 wraps to 0 and carries to minutes.
  - minutes 59 -> 0 carries to hours.
  - hours 23 -> 0.
  - All carries resolve in the same cycle; registered outputs update 1 cycle after the tick cycle.
  - sec_tick registered with the seconds update.
- FSM transitions, on mode_pulse:
  - RUN -> SET_HOUR
  - SET_HOUR -> SET_MIN
  - SET_MIN -> RUN
  - Leaving SET_MIN also clears seconds to 0 and prescaler to 0, so time restarts at hh:mm:00 exactly one full second later.
- SET_HOUR / SET_MIN:
  - Seconds frozen; no carries; sec_tick=0.
  - inc_pulse increments the selected field only, wrapping 23->0 or 59->0, with no carry into hours.
  - Field updates 1 cycle after the pulse.
- Simultaneous events:
  - mode_pulse and inc_pulse in the same cycle: mode wins, inc is dropped.
  - inc_pulse in RUN: ignored.
  - tick coinciding with mode_pulse from RUN: the tick is not applied (state is no longer RUN); seconds hold.
- Blink:
  - In a SET state, toggles every BLINK_DIV ticks.
  - Forced to 0 and its counter cleared on every state change.
  - inc_pulse forces blink=0 for the following cycle so the new value is visible.
- Illegal set_mode encoding (3): next state is RUN.
- Reset mid-set returns to RUN at 00:00:00.
- Width rule: all comparisons against constants are done before increment, so no out-of-range value is ever registered.

Decomposition:
- Shared package watch_pkg:
  - mode encodings MODE_RUN / MODE_SET_HOUR / MODE_SET_MIN
  - HOURS_MAX=23, MIN_MAX=59, SEC_MAX=59
  - field widths
- Sub-module tick_gen (prescaler): CLK_HZ parameter, clear input, one-cycle tick output. This is the natural sub-module. Counters and FSM stay in the top.

Test Plan:
- CLK_HZ=10, reset then 600 cycles -> seconds reaches 59 then minutes=1, seconds=0 at cycle 600; sec_tick pulse count=60.
- Preload via set flow to 23:59, exit to RUN, wait 60 ticks -> hours=0, minutes=0, seconds=0 (full wrap).
- mode_pulse, then 25 inc_pulse -> set_mode=1, hours=1 (wrap at 24); minutes and seconds unchanged.
- From SET_MIN with seconds=37, mode_pulse -> set_mode=0, seconds=0, first sec_tick exactly 10 cycles later.
- mode_pulse and inc_pulse asserted same cycle in SET_HOUR -> set_mode=2, hours unchanged.
- reset_n low mid-cycle while in SET_MIN at 12:34 -> outputs 0 immediately (async, before next edge), set_mode=0, blink=0.

Source files
------------

// File: rtl/watch_pkg.sv
// Shared encodings, field widths and limits for the watch time-keeping path.
package watch_pkg;

  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;
  localparam int SEC_W  = 6;

  localparam logic [HOUR_W-1:0] HOURS_MAX = 5'd23;
  localparam logic [MIN_W-1:0]  MIN_MAX   = 6'd59;
  localparam logic [SEC_W-1:0]  SEC_MAX   = 6'd59;

  typedef enum logic [1:0] {
    MODE_RUN      = 2'd0,
    MODE_SET_HOUR = 2'd1,
    MODE_SET_MIN  = 2'd2
  } mode_t;

endpackage

// File: rtl/tick_gen.sv
// Prescaler: one-cycle tick every CLK_HZ cycles, tick is combinational on the terminal count.
// clear restarts the count at 0 on the next edge and takes priority over the wrap.
module tick_gen #(
  parameter int CLK_HZ = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] TERM = CW'(CLK_HZ - 1);

  logic [CW-1:0] count;

  assign tick = (count == TERM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (clear || tick)
      count <= '0;
    else
      count <= count + CW'(1);
  end

endmodule

// File: rtl/watch_time_setter.sv
// Wall-clock hh:mm:ss with button-driven set FSM; all outputs registered, 1 cycle after the
// causing tick/pulse. No backpressure: every pulse is consumed in the cycle it arrives.
module watch_time_setter
  import watch_pkg::*;
#(
  parameter int CLK_HZ    = 50000000,
  parameter int BLINK_DIV = 2
) (
  input  logic              userclock,
  input  logic              reset_n,
  input  logic              mode_pulse,
  input  logic              inc_pulse,
  output logic [HOUR_W-1:0] hours,
  output logic [MIN_W-1:0]  minutes,
  output logic [SEC_W-1:0]  seconds,
  output logic [1:0]        set_mode,
  output logic              blink,
  output logic              sec_tick
);

  localparam int BCW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BCW-1:0] BLINK_TERM = BCW'(BLINK_DIV - 1);

  mode_t          state;
  logic [BCW-1:0] blink_cnt;
  logic           tick;
  logic           exit_set;

  assign set_mode = state;
  // Leaving SET_MIN restarts the second so time resumes exactly one second later.
  assign exit_set = mode_pulse && (state == MODE_SET_MIN);

  tick_gen #(.CLK_HZ(CLK_HZ)) u_tick_gen (
    .clk   (userclock),
    .rst_n (reset_n),
    .clear (exit_set),
    .tick  (tick)
  );

  always_ff @(posedge userclock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= MODE_RUN;
      hours     <= '0;
      minutes   <= '0;
      seconds   <= '0;
      blink     <= 1'b0;
      blink_cnt <= '0;
      sec_tick  <= 1'b0;
    end else begin
      sec_tick <= 1'b0;
      if (mode_pulse) begin
        // Mode wins over inc and over a coincident tick.
        blink     <= 1'b0;
        blink_cnt <= '0;
        case (state)
          MODE_RUN:      state <= MODE_SET_HOUR;
          MODE_SET_HOUR: state <= MODE_SET_MIN;
          MODE_SET_MIN: begin
            state   <= MODE_RUN;
            seconds <= '0;
          end
          default:       state <= MODE_RUN;
        endcase
      end else begin
        case (state)
          MODE_RUN: begin
            if (tick) begin
              sec_tick <= 1'b1;
              if (seconds == SEC_MAX) begin
                seconds <= '0;
                if (minutes == MIN_MAX) begin
                  minutes <= '0;
                  hours   <= (hours == HOURS_MAX) ? '0 : hours + HOUR_W'(1);
                end else begin
                  minutes <= minutes + MIN_W'(1);
                end
              end else begin
                seconds <= seconds + SEC_W'(1);
              end
            end
          end
          MODE_SET_HOUR, MODE_SET_MIN: begin
            if (tick) begin
              if (blink_cnt == BLINK_TERM) begin
                blink_cnt <= '0;
                blink     <= ~blink;
              end else begin
                blink_cnt <= blink_cnt + BCW'(1);
              end
            end
            if (inc_pulse) begin
              blink <= 1'b0;
              if (state == MODE_SET_HOUR)
                hours <= (hours == HOURS_MAX) ? '0 : hours + HOUR_W'(1);
              else
                minutes <= (minutes == MIN_MAX) ? '0 : minutes + MIN_W'(1);
            end
          end
          default: begin
            state     <= MODE_RUN;
            blink     <= 1'b0;
            blink_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_watch_time_setter.sv
// Directed bench for watch_time_setter with CLK_HZ=10, BLINK_DIV=2 and a scoreboard queue.
module tb_watch_time_setter;

  logic       userclock;
  logic       reset_n;
  logic       mode_pulse;
  logic       inc_pulse;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic [1:0] set_mode;
  logic       blink;
  logic       sec_tick;

  watch_time_setter #(.CLK_HZ(10), .BLINK_DIV(2)) dut (
    .userclock  (userclock),
    .reset_n    (reset_n),
    .mode_pulse (mode_pulse),
    .inc_pulse  (inc_pulse),
    .hours      (hours),
    .minutes    (minutes),
    .seconds    (seconds),
    .set_mode   (set_mode),
    .blink      (blink),
    .sec_tick   (sec_tick)
  );

  initial begin
    userclock = 1'b0;
    forever #5 userclock = ~userclock;
  end

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   tick_count = 0;

  always @(posedge userclock) begin
    #1;
    if (sec_tick === 1'b1) tick_count++;
  end

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    compared++;
    if (sb.size() == 0) begin
      mismatched++;
      $error("FAIL scoreboard_empty: observed %0d with no expected value queued", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        mismatched++;
        $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge userclock);
  endtask

  // One-cycle pulse seen by exactly one rising edge; returns at the following falling edge.
  task automatic pulse(input logic m, input logic i);
    mode_pulse = m;
    inc_pulse  = i;
    step(1);
    mode_pulse = 1'b0;
    inc_pulse  = 1'b0;
  endtask

  task automatic press_inc(input int n);
    for (int k = 0; k < n; k++) begin
      pulse(1'b0, 1'b1);
      step(1);
    end
  endtask

  task automatic wait_blink_high(input int limit);
    for (int k = 0; k < limit; k++) begin
      if (blink === 1'b1) break;
      step(1);
    end
  endtask

  logic [16:0] hms;
  assign hms = {hours, minutes, seconds};

  initial begin
    int lat;
    reset_n    = 1'b0;
    mode_pulse = 1'b0;
    inc_pulse  = 1'b0;

    #2;
    push("reset_hms", 32'd0);       check(32'(hms));
    push("reset_mode", 32'd0);      check(32'(set_mode));
    push("reset_blink_tick", 32'd0); check(32'({blink, sec_tick}));

    step(2);
    reset_n = 1'b1;

    // Free run from reset: 59 s after 590 cycles, 00:01:00 after 600, 60 second pulses.
    push("run_sec59", 32'd59);        step(590); check(32'(seconds));
    push("run_1min", 32'({5'd0, 6'd1, 6'd0})); step(10); check(32'(hms));
    push("run_tick_count", 32'd60);   check(32'(tick_count));

    // SET_HOUR with 25 increments wraps to 1; other fields untouched.
    push("enter_set_hour", 32'd1);    pulse(1'b1, 1'b0); check(32'(set_mode));
    press_inc(24);
    push("hour_wrap_hms", 32'({5'd1, 6'd1, 6'd0}));
    push("blink_after_inc", 32'd0);
    pulse(1'b0, 1'b1);
    check(32'(hms));
    check(32'(blink));
    step(1);
    push("blink_toggles", 32'd1);     wait_blink_high(30); check(32'(blink));

    press_inc(22);
    push("hour_23", 32'd23);          check(32'(hours));

    // Mode and inc together: mode wins, hours hold, blink cleared on state change.
    push("mode_inc_mode", 32'd2);
    push("mode_inc_hours", 32'd23);
    push("mode_inc_blink", 32'd0);
    pulse(1'b1, 1'b1);
    check(32'(set_mode));
    check(32'(hours));
    check(32'(blink));

    // Minutes 1 -> 59 -> 0 (no carry into hours) -> 59.
    press_inc(58);
    push("min_59", 32'd59);           check(32'(minutes));
    push("min_wrap", 32'({5'd23, 6'd0, 6'd0})); press_inc(1); check(32'(hms));
    press_inc(59);
    push("preload_2359", 32'({5'd23, 6'd59, 6'd0})); check(32'(hms));

    // Exit to RUN, full day wrap after 60 seconds.
    push("exit_mode", 32'd0);         pulse(1'b1, 1'b0); check(32'(set_mode));
    push("pre_wrap", 32'({5'd23, 6'd59, 6'd59})); step(590); check(32'(hms));
    push("day_wrap", 32'd0);          step(10); check(32'(hms));

    // Freeze at 37 s in SET_MIN, exit clears seconds and restarts the second.
    for (int k = 0; k < 500; k++) begin
      if (seconds === 6'd37) break;
      step(1);
    end
    pulse(1'b1, 1'b0);
    push("setmin_mode", 32'd2);
    push("setmin_frozen_sec", 32'd37);
    pulse(1'b1, 1'b0);
    check(32'(set_mode));
    check(32'(seconds));
    push("exit37_mode", 32'd0);
    push("exit37_sec", 32'd0);
    pulse(1'b1, 1'b0);
    check(32'(set_mode));
    check(32'(seconds));
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      step(1);
      if (sec_tick === 1'b1) begin
        lat = n;
        break;
      end
    end
    push("first_tick_latency", 32'd10); check(32'(lat));

    // Set 12:34 and assert reset mid-cycle while blinking in SET_MIN.
    pulse(1'b1, 1'b0);
    press_inc(12);
    pulse(1'b1, 1'b0);
    press_inc(34);
    push("set_1234", 32'({5'd12, 6'd34})); check(32'({hours, minutes}));
    push("blink_setmin", 32'd1);      wait_blink_high(30); check(32'(blink));
    #2;
    reset_n = 1'b0;
    #1;
    push("async_rst_hms", 32'd0);     check(32'(hms));
    push("async_rst_mode", 32'd0);    check(32'(set_mode));
    push("async_rst_blink", 32'd0);   check(32'(blink));
    step(2);
    reset_n = 1'b1;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
